vid_timing_meas: RTL and testbench

VID_TIMING_MEAS -- requirements
Module: vid_timing_meas

---
 rtl/vid_timing_meas_pkg.sv | 13 +
 rtl/vtm_edge_det.sv | 21 ++
 rtl/vid_timing_meas.sv | 227 ++++++++++++++++++++++
 tb/tb_vid_timing_meas.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_timing_meas_pkg.sv
// Shared types and constants for the video timing measurement block.
// Holds the lock FSM state encoding and the pixel-error counter width.
package vid_timing_pkg;

    typedef enum logic [1:0] {
        SEEK    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } vtmState_t;

    localparam int PIX_ERR_CNT_W = 16;

endpackage

// File: rtl/vtm_edge_det.sv
// Rising-edge detector for one sync input: registered history plus a rise
// pulse that is valid in the same cycle the new level is presented.
module vtm_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic sigPrev,
    output logic rise
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sigPrev <= 1'b0;
        end else begin
            sigPrev <= sig;
        end
    end

    assign rise = sig & ~sigPrev;

endmodule

// File: rtl/vid_timing_meas.sv
// Measures line/frame timing of an incoming video stream and reports lock.
// Define VTM_PATTERN_CHK_EN to add the incrementing grey-ramp pixel checker.
module vid_timing_meas
    import vid_timing_pkg::*;
#(
    parameter int PW     = 8,
    parameter int H_BITS = 12,
    parameter int V_BITS = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     hs,
    input  logic                     vs,
    input  logic                     vld,
    input  logic [3*PW-1:0]          rgb,
    output logic [H_BITS-1:0]        meas_h_total,
    output logic [H_BITS-1:0]        meas_h_act,
    output logic [V_BITS-1:0]        meas_v_total,
    output logic [V_BITS-1:0]        meas_v_act,
    output logic                     locked,
    output logic                     unlock,
    output logic                     pix_err,
    output logic [PIX_ERR_CNT_W-1:0] pix_err_cnt
);

    localparam logic [H_BITS-1:0] H_MAX = '1;
    localparam logic [V_BITS-1:0] V_MAX = '1;

    logic [1:0] syncIn;
    logic [1:0] syncHist;
    logic [1:0] syncRise;
    logic       hsRise;
    logic       vsRise;
    logic       unusedHist;

    assign syncIn = {vs, hs};

    for (genvar gi = 0; gi < 2; gi++) begin : g_edge
        vtm_edge_det u_edge (
            .clk     (clk),
            .rst_n   (rst_n),
            .sig     (syncIn[gi]),
            .sigPrev (syncHist[gi]),
            .rise    (syncRise[gi])
        );
    end

    assign hsRise     = syncRise[0];
    assign vsRise     = syncRise[1];
    assign unusedHist = ^syncHist;

    logic [H_BITS-1:0] hcyc;
    logic [H_BITS-1:0] acnt;
    logic [H_BITS-1:0] lastPeriod;
    logic [H_BITS-1:0] refAct;
    logic [V_BITS-1:0] vtot;
    logic [V_BITS-1:0] vact;
    logic              haveLine;
    logic              frameBad;

    logic              lineActive;
    logic              lineBad;
    logic [H_BITS-1:0] closePeriod;
    logic [H_BITS-1:0] closeAct;
    logic [V_BITS-1:0] closeVtot;
    logic [V_BITS-1:0] closeVact;
    logic              closeBad;
    logic              measDiff;

    // Blank lines carry no active pixels, so active counts are only compared
    // between lines that actually had pixels; periods are compared every line.
    assign lineActive = (acnt != '0);
    assign lineBad    = (haveLine && (hcyc != lastPeriod)) ||
                        (lineActive && (refAct != '0) && (acnt != refAct));

    // Frame results as they stand this cycle, folding in a line closed by a
    // coincident hs rise so it belongs to the frame that is ending.
    assign closeVtot   = (hsRise && vtot != V_MAX) ? vtot + V_BITS'(1) : vtot;
    assign closeVact   = (hsRise && lineActive && vact != V_MAX) ? vact + V_BITS'(1) : vact;
    assign closePeriod = hsRise ? hcyc : lastPeriod;
    assign closeAct    = (hsRise && lineActive) ? acnt : refAct;
    assign closeBad    = frameBad | (hsRise & lineBad);
    assign measDiff    = (closePeriod != meas_h_total) || (closeAct != meas_h_act) ||
                         (closeVtot   != meas_v_total) || (closeVact != meas_v_act);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcyc       <= '0;
            acnt       <= '0;
            lastPeriod <= '0;
            refAct     <= '0;
            vtot       <= '0;
            vact       <= '0;
            haveLine   <= 1'b0;
            frameBad   <= 1'b0;
        end else begin
            if (hsRise) begin
                hcyc <= H_BITS'(1);
            end else if (hcyc != H_MAX) begin
                hcyc <= hcyc + H_BITS'(1);
            end

            if (hsRise) begin
                acnt <= H_BITS'(vld);
            end else if (vld && acnt != H_MAX) begin
                acnt <= acnt + H_BITS'(1);
            end

            if (hsRise) begin
                lastPeriod <= hcyc;
            end

            if (vsRise) begin
                vtot     <= '0;
                vact     <= '0;
                refAct   <= '0;
                haveLine <= 1'b0;
                frameBad <= 1'b0;
            end else if (hsRise) begin
                vtot     <= closeVtot;
                vact     <= closeVact;
                haveLine <= 1'b1;
                frameBad <= frameBad | lineBad;
                if (lineActive) begin
                    refAct <= acnt;
                end
            end
        end
    end

    vtmState_t state;
    logic      haveMeas;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= SEEK;
            meas_h_total <= '0;
            meas_h_act   <= '0;
            meas_v_total <= '0;
            meas_v_act   <= '0;
            locked       <= 1'b0;
            unlock       <= 1'b0;
            haveMeas     <= 1'b0;
        end else begin
            unlock <= 1'b0;
            case (state)
                SEEK: begin
                    if (vsRise) begin
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (vsRise) begin
                        meas_h_total <= closePeriod;
                        meas_h_act   <= closeAct;
                        meas_v_total <= closeVtot;
                        meas_v_act   <= closeVact;
                        // A bad frame is not trusted as a reference for the next one.
                        haveMeas     <= !closeBad;
                        if (!closeBad && haveMeas && !measDiff) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (vsRise) begin
                        meas_h_total <= closePeriod;
                        meas_h_act   <= closeAct;
                        meas_v_total <= closeVtot;
                        meas_v_act   <= closeVact;
                        if (closeBad || measDiff) begin
                            state    <= MEASURE;
                            locked   <= 1'b0;
                            unlock   <= 1'b1;
                            haveMeas <= !closeBad;
                        end
                    end
                end
                default: begin
                    state  <= SEEK;
                    locked <= 1'b0;
                end
            endcase
        end
    end

`ifdef VTM_PATTERN_CHK_EN
    logic [PW-1:0] rPix;
    logic [PW-1:0] gPix;
    logic [PW-1:0] bPix;
    logic [PW-1:0] refR;
    logic          seeded;
    logic          pixBad;

    assign {rPix, gPix, bPix} = rgb;
    assign pixBad = vld && seeded &&
                    ((gPix != rPix) || (bPix != rPix) || (rPix != refR + PW'(1)));

    // The reference always follows the received value, so a single corrupt
    // pixel costs at most two errors instead of desynchronising the ramp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refR        <= '0;
            seeded      <= 1'b0;
            pix_err     <= 1'b0;
            pix_err_cnt <= '0;
        end else begin
            pix_err <= pixBad;
            if (vld) begin
                refR   <= rPix;
                seeded <= 1'b1;
            end
            if (pixBad && pix_err_cnt != '1) begin
                pix_err_cnt <= pix_err_cnt + PIX_ERR_CNT_W'(1);
            end
        end
    end
`else
    logic unusedRgb;

    assign unusedRgb   = ^rgb;
    assign pix_err     = 1'b0;
    assign pix_err_cnt = '0;
`endif

endmodule

// File: tb/tb_vid_timing_meas.sv
// Scoreboard bench for vid_timing_meas: frames push expected results, a
// monitor compares them one cycle after each vs rise seen by the DUT.
module tb_vid_timing_meas;

    logic        clk;
    logic        rst_n;
    logic        hs;
    logic        vs;
    logic        vld;
    logic [23:0] rgb;
    logic [11:0] meas_h_total;
    logic [11:0] meas_h_act;
    logic [11:0] meas_v_total;
    logic [11:0] meas_v_act;
    logic        locked;
    logic        unlock;
    logic        pix_err;
    logic [15:0] pix_err_cnt;

    typedef struct {
        int ht;
        int ha;
        int vt;
        int va;
        int lk;
        int ul;
    } exp_t;

    exp_t expQ[$];
    int   errors    = 0;
    int   checks    = 0;
    int   pixPulses = 0;
    int   frameNum  = 0;
    logic [7:0] pixR;

`ifdef VTM_PATTERN_CHK_EN
    localparam int EXP_ERR1 = 1;
    localparam int EXP_ERR2 = 2;
`else
    localparam int EXP_ERR1 = 0;
    localparam int EXP_ERR2 = 0;
`endif

    vid_timing_meas #(.PW(8), .H_BITS(12), .V_BITS(12)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hs           (hs),
        .vs           (vs),
        .vld          (vld),
        .rgb          (rgb),
        .meas_h_total (meas_h_total),
        .meas_h_act   (meas_h_act),
        .meas_v_total (meas_v_total),
        .meas_v_act   (meas_v_act),
        .locked       (locked),
        .unlock       (unlock),
        .pix_err      (pix_err),
        .pix_err_cnt  (pix_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_h_total"}, int'(meas_h_total), 0);
        check({tag, "_h_act"},   int'(meas_h_act),   0);
        check({tag, "_v_total"}, int'(meas_v_total), 0);
        check({tag, "_v_act"},   int'(meas_v_act),   0);
        check({tag, "_locked"},  int'(locked),       0);
        check({tag, "_unlock"},  int'(unlock),       0);
        check({tag, "_pix_err"}, int'(pix_err),      0);
        check({tag, "_pix_cnt"}, int'(pix_err_cnt),  0);
    endtask

    task automatic sendPix(input logic [23:0] v);
        tick();
        vld = 1'b1;
        rgb = v;
        tick();
        vld = 1'b0;
    endtask

    // One frame: vs with hs on line 0, 16 vld pixels on lines 0..9.
    // The expectation belongs to the vs rise that opens this frame.
    task automatic sendFrame(input int period, input int nLines, input int badIdx,
                             input int badVld, input int extra,
                             input int eht, input int eha, input int evt,
                             input int eva, input int elk, input int eul);
        exp_t e;
        e.ht = eht; e.ha = eha; e.vt = evt; e.va = eva; e.lk = elk; e.ul = eul;
        expQ.push_back(e);
        for (int ln = 0; ln < nLines; ln++) begin
            int len;
            int nv;
            len = period + ((ln == nLines - 1) ? extra : 0);
            nv  = (ln == badIdx) ? badVld : 16;
            for (int c = 0; c < len; c++) begin
                tick();
                hs  = (c == 0);
                vs  = (ln == 0) && (c < 3);
                vld = (ln < 10) && (c >= 2) && (c < 2 + nv);
                if (vld) begin
                    rgb  = {3{pixR}};
                    pixR = pixR + 8'd1;
                end else begin
                    rgb = '0;
                end
            end
        end
    endtask

    // Monitor: vs rise visible at a negedge is acted on at the next posedge,
    // so results are compared at the negedge after that.
    initial begin
        logic vsLast;
        bit   pending;
        bit   unlockFollow;
        exp_t e;
        vsLast       = 1'b0;
        pending      = 1'b0;
        unlockFollow = 1'b0;
        forever begin
            @(negedge clk);
            if (pix_err) pixPulses++;
            if (!rst_n) begin
                vsLast       = 1'b0;
                pending      = 1'b0;
                unlockFollow = 1'b0;
            end else begin
                if (unlockFollow) begin
                    check("unlock_one_cycle", int'(unlock), 0);
                    unlockFollow = 1'b0;
                end
                if (pending) begin
                    frameNum++;
                    if (expQ.size() == 0) begin
                        check("sb_underflow", expQ.size(), 1);
                    end else begin
                        e = expQ.pop_front();
                        $display("vs#%0d ht=%0d ha=%0d vt=%0d va=%0d locked=%0b unlock=%0b",
                                 frameNum, meas_h_total, meas_h_act, meas_v_total,
                                 meas_v_act, locked, unlock);
                        check("meas_h_total", int'(meas_h_total), e.ht);
                        check("meas_h_act",   int'(meas_h_act),   e.ha);
                        check("meas_v_total", int'(meas_v_total), e.vt);
                        check("meas_v_act",   int'(meas_v_act),   e.va);
                        check("locked",       int'(locked),       e.lk);
                        check("unlock",       int'(unlock),       e.ul);
                        if (e.ul != 0) unlockFollow = 1'b1;
                    end
                    pending = 1'b0;
                end
                if (vs && !vsLast) pending = 1'b1;
                vsLast = vs;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        hs    = 1'b0;
        vs    = 1'b0;
        vld   = 1'b0;
        rgb   = '0;
        pixR  = 8'h00;
        repeat (3) tick();
        checkAllZero("reset");
        rst_n = 1'b1;
        repeat (2) tick();

        // Pixel ramp checker: 0x07 skips a step, 0x090A09 has g off.
        sendPix(24'h040404);
        sendPix(24'h050505);
        sendPix(24'h070707);
        tick();
        check("pix_cnt_after_skip", int'(pix_err_cnt), EXP_ERR1);
        sendPix(24'h080808);
        tick();
        check("pix_cnt_after_resync", int'(pix_err_cnt), EXP_ERR1);
        sendPix(24'h090A09);
        tick();
        check("pix_cnt_after_gbad", int'(pix_err_cnt), EXP_ERR2);
        pixR = 8'h0A;

        //        per  ln  bad bv  extra  ht    ha  vt  va  lk ul
        sendFrame(20, 12, -1, 0,  0,      0,   0,  0,  0, 0, 0); // SEEK
        sendFrame(20, 12, -1, 0,  0,     20,  16, 12, 10, 0, 0);
        sendFrame(20, 12, -1, 0,  0,     20,  16, 12, 10, 1, 0);
        sendFrame(21, 12, -1, 0,  0,     20,  16, 12, 10, 1, 0);
        sendFrame(21, 12, -1, 0,  0,     21,  16, 12, 10, 0, 1);
        sendFrame(21, 12,  3, 15, 0,     21,  16, 12, 10, 1, 0);
        sendFrame(21, 12, -1, 0,  0,     21,  16, 12, 10, 0, 1); // bad frame
        sendFrame(21, 12, -1, 0,  0,     21,  16, 12, 10, 0, 0);
        sendFrame(20, 12, -1, 0,  4980,  21,  16, 12, 10, 1, 0);
        sendFrame(20, 12, -1, 0,  0,   4095,  16, 12, 10, 0, 1); // saturated line
        sendFrame(20, 12, -1, 0,  0,     20,  16, 12, 10, 0, 0);
        sendFrame(20, 5,  -1, 0,  0,     20,  16, 12, 10, 1, 0);

        check("locked_before_reset", int'(locked), 1);
        rst_n = 1'b0;
        hs    = 1'b0;
        vs    = 1'b0;
        vld   = 1'b0;
        #1;
        checkAllZero("midreset");
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        sendFrame(20, 12, -1, 0,  0,      0,   0,  0,  0, 0, 0); // SEEK again
        sendFrame(20, 12, -1, 0,  0,     20,  16, 12, 10, 0, 0);
        sendFrame(20, 12, -1, 0,  0,     20,  16, 12, 10, 1, 0);
        sendFrame(20, 2,  -1, 0,  0,     20,  16, 12, 10, 1, 0);
        repeat (5) tick();

        check("sb_drain", expQ.size(), 0);
        check("pix_err_pulses", pixPulses, EXP_ERR2);
        check("pix_cnt_final", int'(pix_err_cnt), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
